// File: rtl/rotator_pkg.sv
// Shared constants, request type and the three-stage right-rotate helper
// used by the rotator round-robin arbiter.
package rotator_pkg;

    localparam int DATA_W  = 8;
    localparam int SHIFT_W = 3;

    typedef struct packed {
        logic [7:0] data;
        logic [2:0] shift;
    } rot_req_t;

    // Log-shifter: each stage rotates by 1, 2 or 4 under one shift bit.
    function automatic logic [7:0] rotr8(input logic [7:0] data, input logic [2:0] shift);
        logic [7:0] s1;
        logic [7:0] s2;
        logic [7:0] s3;
        s1 = shift[0] ? {data[0],   data[7:1]} : data;
        s2 = shift[1] ? {s1[1:0],   s1[7:2]}   : s1;
        s3 = shift[2] ? {s2[3:0],   s2[7:4]}   : s2;
        return s3;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: holds the last-grant pointer and issues a one-hot
// grant to the first request found after the pointer, wrapping modulo N.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req_i,
    input  logic          advance_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] grant_idx_o
);

    logic [IW-1:0] last_q;
    logic [IW-1:0] last_d;

    // Search runs from farthest to nearest so the nearest candidate wins.
    always_comb begin
        logic [IW:0]   sum;
        logic [IW-1:0] cand;
        grant_o     = '0;
        grant_idx_o = '0;
        sum         = '0;
        cand        = '0;
        for (int k = N; k >= 1; k--) begin
            sum = {1'b0, last_q} + (IW+1)'(k);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            cand = sum[IW-1:0];
            if (req_i[cand]) begin
                grant_o       = '0;
                grant_o[cand] = 1'b1;
                grant_idx_o   = cand;
            end
        end
    end

    always_comb begin
        last_d = last_q;
        if (advance_i) begin
            last_d = grant_idx_o;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= IW'(N-1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/rotator_rr_arbiter.sv
// Shares one 8-bit right-rotate datapath among NUM_REQ requesters through a
// round-robin arbiter and a single-entry valid/ready response register.
module rotator_rr_arbiter
    import rotator_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            reqValid,
    output logic [NUM_REQ-1:0]            reqReady,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]  reqData,
    input  logic [NUM_REQ-1:0][SHIFT_W-1:0] reqShift,
    output logic                          rspValid,
    input  logic                          rspReady,
    output logic [DATA_W-1:0]             rspData,
    output logic [ID_W-1:0]               rspId,
    output logic                          busy
);

    // Handshakes: a transfer happens on an edge where valid && ready are both
    // high. Producers hold data stable while valid is high and unaccepted, and
    // never make valid depend on ready; ready here may depend on valid.

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               accept_en;
    logic               hs;
    rot_req_t           sel;

    logic               rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_data_q,  rsp_data_d;
    logic [ID_W-1:0]    rsp_id_q,    rsp_id_d;

    assign accept_en = !rsp_valid_q || rspReady;
    assign hs        = accept_en && (|reqValid) && !reset;
    assign reqReady  = (accept_en && !reset) ? grant : '0;
    assign busy      = rsp_valid_q || (|reqValid);

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk         (clk),
        .rst         (reset),
        .req_i       (reqValid),
        .advance_i   (hs),
        .grant_o     (grant),
        .grant_idx_o (grant_idx)
    );

    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel.data  = reqData[i];
                sel.shift = reqShift[i];
            end
        end
    end

    // A drain with no new handshake clears valid but leaves data/id as-is.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        if (hs) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = rotr8(sel.data, sel.shift);
            rsp_id_d    = grant_idx;
        end else if (rspReady) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign rspValid = rsp_valid_q;
    assign rspData  = rsp_data_q;
    assign rspId    = rsp_id_q;

endmodule

// File: tb/tb_rotator_rr_arbiter.sv
// Self-checking bench for rotator_rr_arbiter: directed steps plus a random
// phase against a cycle-level reference model and an ordering scoreboard.
module tb_rotator_rr_arbiter;

    localparam int N    = 4;
    localparam int ID_W = 2;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [N-1:0]         reqValid;
    logic [N-1:0]         reqReady;
    logic [N-1:0][7:0]    reqData;
    logic [N-1:0][2:0]    reqShift;
    logic                 rspValid;
    logic                 rspReady;
    logic [7:0]           rspData;
    logic [ID_W-1:0]      rspId;
    logic                 busy;

    rotator_rr_arbiter #(.NUM_REQ(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .reqValid (reqValid),
        .reqReady (reqReady),
        .reqData  (reqData),
        .reqShift (reqShift),
        .rspValid (rspValid),
        .rspReady (rspReady),
        .rspData  (rspData),
        .rspId    (rspId),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Requester-side state: what each producer is currently presenting.
    bit         pend_v [N];
    logic [7:0] pend_d [N];
    logic [2:0] pend_s [N];
    bit         refill = 1'b0;
    logic       rdy    = 1'b1;

    // Reference model of the response register and pointer.
    bit         m_valid = 1'b0;
    logic [7:0] m_data  = 8'h00;
    int         m_id    = 0;
    int         m_last  = N-1;
    logic [N-1:0] seen_ready;

    logic [ID_W+7:0] exp_q [$];

    function automatic logic [7:0] model_rot(input int d, input int s);
        return 8'(((d >> s) | (d << (8 - s))) & 255);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic present(input int i, input logic [7:0] d, input logic [2:0] s);
        pend_v[i] = 1'b1;
        pend_d[i] = d;
        pend_s[i] = s;
    endtask

    // Called at posedge+1; returns at the following posedge+1.
    task automatic step();
        bit acc;
        bit any;
        int g;
        int idx;
        logic [N-1:0] exp_ready;
        logic [ID_W+7:0] e;
        any = 1'b0;
        for (int i = 0; i < N; i++) begin
            reqValid[i] = pend_v[i];
            reqData[i]  = pend_d[i];
            reqShift[i] = pend_s[i];
            any = any | pend_v[i];
        end
        rspReady = rdy;
        #1;
        acc = !m_valid || rdy;
        g = -1;
        for (int k = 1; k <= N; k++) begin
            idx = (m_last + k) % N;
            if (g < 0 && pend_v[idx]) g = idx;
        end
        exp_ready = (acc && g >= 0) ? N'(1 << g) : '0;
        seen_ready = reqReady;
        check("reqReady", reqReady, exp_ready);
        check("busy", busy, m_valid || any);
        if (m_valid && rdy) begin
            check("sb_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_data", rspData, e[7:0]);
                check("sb_id", rspId, e[ID_W+7:8]);
            end
        end
        @(posedge clk);
        if (acc && g >= 0) begin
            m_data  = model_rot(pend_d[g], pend_s[g]);
            m_id    = g;
            m_valid = 1'b1;
            m_last  = g;
            exp_q.push_back({ID_W'(g), m_data});
            pend_v[g] = 1'b0;
            if (refill) present(g, 8'($urandom), 3'($urandom));
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        #1;
        check("rspValid", rspValid, m_valid);
        check("rspData", rspData, m_data);
        check("rspId", rspId, m_id);
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = 8'h00;
        m_id    = 0;
        m_last  = N-1;
        exp_q.delete();
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            pend_v[i] = 1'b0;
            pend_d[i] = 8'h00;
            pend_s[i] = 3'd0;
        end
        reset    = 1'b1;
        reqValid = '1;
        reqData  = '0;
        reqShift = '0;
        rspReady = 1'b1;
        #12;
        check("reset_rspValid", rspValid, 0);
        check("reset_rspData", rspData, 0);
        check("reset_rspId", rspId, 0);
        check("reset_reqReady", reqReady, 0);
        reqValid = '0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single request on requester 1.
        rdy = 1'b1;
        present(1, 8'hB4, 3'd3);
        step();
        check("single_ready", seen_ready, 4'b0010);
        check("single_data", rspData, 8'h96);
        check("single_id", rspId, 1);
        step();

        // Rotate corner cases.
        present(0, 8'h81, 3'd0); step(); check("rot_81_0", rspData, 8'h81);
        present(0, 8'h81, 3'd1); step(); check("rot_81_1", rspData, 8'hC0);
        present(0, 8'h81, 3'd7); step(); check("rot_81_7", rspData, 8'h03);
        present(0, 8'h01, 3'd4); step(); check("rot_01_4", rspData, 8'h10);

        // Park the pointer on 3, then all requesters continuously valid.
        present(3, 8'h00, 3'd0);
        step();
        for (int i = 0; i < N; i++) present(i, 8'($urandom), 3'($urandom));
        refill = 1'b1;
        for (int t = 0; t < 6; t++) begin
            step();
            check("rr_id", rspId, t % N);
            check("rr_valid", rspValid, 1);
        end
        refill = 1'b0;
        for (int t = 0; t < N + 1; t++) step();

        // Backpressure with requesters 2 and 3 waiting after a grant to 1.
        present(1, 8'h3C, 3'd2);
        step();
        present(2, 8'hA5, 3'd5);
        present(3, 8'h5A, 3'd6);
        rdy = 1'b0;
        for (int t = 0; t < 5; t++) begin
            step();
            check("bp_ready", seen_ready, 0);
            check("bp_id", rspId, 1);
            check("bp_data", rspData, 8'h0F);
        end
        rdy = 1'b1;
        step();
        check("bp_release_grant", seen_ready, 4'b0100);
        step();
        check("bp_next_grant", seen_ready, 4'b1000);
        step();

        // Simultaneous drain and accept.
        present(1, 8'hFF, 3'd1);
        step();
        present(0, 8'h5A, 3'd2);
        step();
        check("sim_ready", seen_ready, 4'b0001);
        check("sim_valid", rspValid, 1);
        check("sim_data", rspData, 8'h96);
        check("sim_id", rspId, 0);

        // Asynchronous reset with a held response and requests in flight.
        present(2, 8'h77, 3'd3);
        step();
        present(0, 8'h12, 3'd1);
        present(3, 8'h34, 3'd2);
        #2;
        reset    = 1'b1;
        reqValid = 4'b1001;
        #1;
        check("mid_reset_rspValid", rspValid, 0);
        check("mid_reset_rspData", rspData, 0);
        check("mid_reset_rspId", rspId, 0);
        check("mid_reset_reqReady", reqReady, 0);
        model_reset();
        reqValid = '0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        step();
        check("post_reset_grant", seen_ready, 4'b0001);
        step();
        step();

        // Random traffic.
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend_v[i] && $urandom_range(0, 1) == 1)
                    present(i, 8'($urandom), 3'($urandom));
            end
            rdy = ($urandom_range(0, 3) != 0);
            step();
        end

        rdy = 1'b1;
        for (int t = 0; t < N + 2; t++) step();
        check("sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
